// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with preset load and a one-cycle done pulse.
// Optional feature macro: AUTO_RELOAD_EN (reload the preset when leaving DONE).
module bcd_down_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   input  logic                  x,
   output logic [4*DIGITS-1:0]   q,
   output logic                  zero,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            state_dbg
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   q_next;
   logic [W-1:0]   din_clamped;
   logic [W-1:0]   q_dec;
   logic           borrow;
   logic           busy_next;
   logic           done_next;

`ifdef AUTO_RELOAD_EN
   logic [W-1:0]   reload_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reload_q <= '0;
      end else if (load) begin
         reload_q <= din_clamped;
      end
   end
`endif

   // Non-decimal nibbles saturate to 9 so the count always stays valid BCD.
   always_comb begin
      din_clamped = '0;
      for (int i = 0; i < DIGITS; i++) begin
         din_clamped[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
      end
   end

   // Ripple borrow: a zero digit under borrow becomes 9 and passes the borrow up.
   always_comb begin
      q_dec  = q;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (q[4*i +: 4] == 4'd0) begin
               q_dec[4*i +: 4] = 4'd9;
            end else begin
               q_dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
               borrow          = 1'b0;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         q     <= q_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      q_next     = q;
      if (load) begin
         q_next     = din_clamped;
         state_next = (din_clamped != '0) ? RUN : DONE;
      end else begin
         case (state)
            IDLE: begin
               state_next = IDLE;
            end
            RUN: begin
               if (x) begin
                  q_next     = q_dec;
                  state_next = (q_dec == '0) ? DONE : RUN;
               end
            end
            DONE: begin
`ifdef AUTO_RELOAD_EN
               if (reload_q != '0) begin
                  q_next     = reload_q;
                  state_next = RUN;
               end else begin
                  state_next = IDLE;
               end
`else
               state_next = IDLE;
`endif
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Output logic: busy/done are decoded from the next state so they are registered
   always_comb begin
      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

   assign zero      = (q == '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS=2); an integer-domain model
// feeds an expected queue that is compared one cycle after each driven step.
module tb_bcd_down_counter;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int EW     = W + 5;

   logic          clk;
   logic          rst;
   logic          load;
   logic [W-1:0]  din;
   logic          x;
   logic [W-1:0]  q;
   logic          zero;
   logic          busy;
   logic          done;
   logic [1:0]    state_dbg;

   int            n_cmp;
   int            n_err;
   logic [EW-1:0] exp_q[$];

   // model state: 0 idle, 1 run, 2 done
   int            m_cnt;
   int            m_state;
   int            m_reload;

   bcd_down_counter #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .din       (din),
      .x         (x),
      .q         (q),
      .zero      (zero),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

   function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   nib;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         nib = v[4*i +: 4];
         if (nib > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   function automatic logic [EW-1:0] model_expect();
      logic [W-1:0] qe;
      logic [1:0]   se;
      qe = int2bcd(m_cnt);
      se = 2'(m_state);
      return {se, qe, (m_state == 1), (m_state == 2), (m_cnt == 0)};
   endfunction

   task automatic model_reset();
      m_cnt    = 0;
      m_state  = 0;
      m_reload = 0;
   endtask

   // driver: apply one cycle of stimulus, advance the model, compare after the edge
   task automatic step(input logic ld, input logic [W-1:0] d, input logic xe, input string tag);
      logic [EW-1:0] e;
      @(negedge clk);
      load = ld;
      din  = d;
      x    = xe;
      if (ld) begin
         m_cnt    = bcd2int(clamp(d));
         m_reload = m_cnt;
         m_state  = (m_cnt != 0) ? 1 : 2;
      end else if (m_state == 1) begin
         if (xe) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_state = 2;
         end
      end else if (m_state == 2) begin
`ifdef AUTO_RELOAD_EN
         if (m_reload != 0) begin
            m_cnt   = m_reload;
            m_state = 1;
         end else begin
            m_state = 0;
         end
`else
         m_state = 0;
`endif
      end
      exp_q.push_back(model_expect());
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'({state_dbg, q, busy, done, zero}), 32'(e));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_reset();
      rst  = 1'b0;
      load = 1'b0;
      din  = '0;
      x    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", 32'(q), 32'h0);
      check("rst_flags", 32'({busy, done, zero}), 32'b001);
      @(negedge clk);
      rst = 1'b1;

      // 1: asynchronous reset mid-run
      step(1'b1, 8'h37, 1'b0, "t1_load");
      step(1'b0, 8'h00, 1'b1, "t1_dec");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("t1_async_q", 32'(q), 32'h0);
      check("t1_async_flags", 32'({busy, done, zero}), 32'b001);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b1, "t1_after");

      // 2: preset 12 counted down with x held high
      step(1'b1, 8'h12, 1'b1, "t2_load");
      for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, "t2_run");
      x = 1'b0;

      // 3: borrow and hold on x=0
      step(1'b1, 8'h20, 1'b0, "t3_load");
      step(1'b0, 8'h00, 1'b1, "t3_borrow");
      step(1'b0, 8'h00, 1'b0, "t3_hold0");
      step(1'b0, 8'h00, 1'b0, "t3_hold1");
      step(1'b0, 8'h00, 1'b1, "t3_dec");

      // 4: clamp and zero preset
      step(1'b1, 8'hAF, 1'b1, "t4_clamp");
      step(1'b1, 8'h00, 1'b1, "t4_zero");
      step(1'b0, 8'h00, 1'b1, "t4_after");
      step(1'b0, 8'h00, 1'b1, "t4_idle");

      // 5: load on the done cycle wins
      step(1'b1, 8'h05, 1'b1, "t5_load");
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, "t5_run");
      step(1'b1, 8'h03, 1'b1, "t5_reload");
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, "t5_tail");

      // 6: periodic done with auto reload, single pulse otherwise
      step(1'b1, 8'h03, 1'b1, "t6_load");
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, "t6_run");

      // random traffic with occasional loads of arbitrary nibbles
      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) != 0), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
Multi-digit BCD down counter (countdown timer). It is the counterpart to the decade up-counter: it is loaded with a BCD value, counts down one step per enabled clock, and flags terminal count with a one-cycle done pulse. Used as a preset event or interval timer beside the decade counters. Each digit borrows into the next digit up.

Parameters:
DIGITS, 2, number of BCD digits; q and din are 4*DIGITS bits wide; legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; low forces the reset state immediately.
load  input  1  synchronous preset strobe; has priority over x.
din  input  4*DIGITS  BCD preset value; nibble i is digit i, digit 0 is the least significant.
x  input  1  count enable; same role as the decade counter's x.
q  output  4*DIGITS  current BCD count, registered.
zero  output  1  combinational; high when q is all zeros.
busy  output  1  registered; high while the FSM is in RUN.
done  output  1  registered; high for exactly one cycle in state DONE.

Behaviour:
- Reset (rst low, asynchronous): q=0, state=IDLE, busy=0, done=0; zero=1. Internal reload register=0.
- The FSM has three states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Load: on a rising edge with load=1, in any state, the counter presets.
  - Each din nibble greater than 9 is clamped to 9 before use.
  - The clamped value is written to q and to the reload register.
  - Next state is RUN if the clamped value is nonzero, otherwise DONE.
  - x is ignored on that edge.
- RUN with x=1, load=0: q decrements by one in BCD on that edge.
  - Digit 0 decrements. A digit that is 0 while borrowing becomes 9 and borrows from the next digit up.
  - If the new q is 0, next state is DONE; otherwise the FSM stays in RUN.
- RUN with x=0: q holds and the state holds.
- DONE lasts exactly one cycle with q=0 and done=1. Next state is IDLE, unless the optional feature applies.
- IDLE: q holds and x is ignored. Only load leaves IDLE.
- Latency:
  - A load edge makes q and busy valid one cycle later.
  - When the decrement reaches 0 at edge n, done is high from edge n to edge n+1.
  - An N-count preset with x held high gives done after N enabled edges.
- Load in the same cycle as done=1: load wins and the FSM goes to RUN (or DONE for a zero preset).
- Reset mid-count discards the count and the reload register. There is no pending done after reset.
- Wrap-around: the counter never counts below 0.

Optional Feature:
AUTO_RELOAD_EN
- Defined: on the edge leaving DONE, q is loaded from the reload register and the FSM returns to RUN. This gives a periodic done pulse every N enabled counts plus one cycle. If the reload register is 0, the FSM goes to IDLE instead. Explicit load still has priority.
- Undefined: DONE always goes to IDLE, and the reload register may be optimised away.

Test Plan (DIGITS=2):
1. Reset with rst=0 mid-run from q=8'h37 → q=8'h00, busy=0, done=0, zero=1, taking effect without a clock edge.
2. Load din=8'h12 with x=1 continuously → q steps 12,11,10,09,…,01,00. done is high for one cycle after the 12th enabled edge, then the FSM goes to IDLE with q=00 held.
3. Load 8'h20 and toggle x (1,0,0,1) → q goes 20→19, holds 19 for two cycles, then goes to 18, showing the borrow and the hold on x=0.
4. Load din=8'hAF → q=8'h99. Load din=8'h00 → done=1 on the next cycle, busy never rises.
5. Load 8'h05 and, on the cycle where done=1, assert load with din=8'h03 → q=03, state RUN, no IDLE cycle.
6. With AUTO_RELOAD_EN: load 8'h03, x=1 → done pulses every 4 cycles and q cycles 03,02,01,00,03… Without the macro → a single done pulse, then IDLE.
